ntt_stream_bridge: RTL and testbench
====================================

Name: ntt_stream_bridge

Overview:
- Stream-side front/back end for the 8-point NTT/iNTT datapath (12-bit coefficients, q = 3329).
- Collects a serial coefficient stream (valid/ready) into an N-wide vector, reduces each coefficient to canonical range, and issues it with a one-cycle valid pulse.
- Captures the returned N-wide vector on the datapath's valid pulse and replays it as a serial valid/ready stream with a last marker.
- Exactly one transform is in flight at a time.

Parameters:
N, 8, coefficients per vector; power of two, >= 2
W, 12, coefficient width in bits
Q, 3329, modulus; must satisfy 2*Q > 2^W - 1

Ports:
clk  input  1  clock; all logic on rising edge
r  input  1  reset; synchronous, active-high
s_coeff  input  W  serial input coefficient
s_valid  input  1  s_coeff is valid
s_ready  output  1  bridge accepts s_coeff this cycle
vec_out  output  W x N (unpacked [N-1:0])  vector to datapath; element i = i-th accepted coefficient
vec_valid  output  1  one-cycle pulse; vec_out is valid
vec_in  input  W x N (unpacked [N-1:0])  vector returned by datapath
vec_in_valid  input  1  vec_in valid this cycle
m_coeff  output  W  serial output coefficient
m_valid  output  1  m_coeff valid
m_ready  input  1  downstream accepts m_coeff
m_last  output  1  high with element N-1 of the output stream
err_unexp  output  1  sticky: vec_in_valid seen outside WAIT

Behaviour:
- Reset (r = 1 at a clk edge):
  - State goes to LOAD; load and drain counters go to 0.
  - vec_out and the capture register go to all zeros.
  - s_ready = 1 in the cycle after reset is released; vec_valid = 0, m_valid = 0, m_coeff = 0, m_last = 0, err_unexp = 0.
  - Reset mid-operation discards any partial vector or undrained data. No pulse is emitted.
- States: LOAD -> ISSUE -> WAIT -> DRAIN -> LOAD.
- LOAD:
  - s_ready = 1. Each cycle with s_valid & s_ready stores red(s_coeff) into vec_out[cnt], then cnt++.
  - red(x) = x - Q if x >= Q, else x. One conditional subtract is sufficient because 2^W - 1 < 2Q. Elements not being written keep their value.
  - When the handshake stores element N-1, go to ISSUE and set cnt to 0.
- ISSUE: vec_valid = 1 for exactly this one cycle; s_ready = 0; go to WAIT.
  - Latency: last input handshake at edge t gives vec_valid high in cycle t+1.
  - vec_out is held stable from ISSUE until the next LOAD write. The first write of the next vector is at least one cycle after the drain completes.
- WAIT:
  - s_ready = 0. On vec_in_valid, capture all N elements of vec_in and go to DRAIN.
  - vec_in_valid in the same cycle as ISSUE is not captured: it sets err_unexp.
  - No timeout; WAIT persists until vec_in_valid or reset.
- DRAIN:
  - m_valid = 1 and m_coeff = capture[dcnt]. m_last = 1 when dcnt = N-1.
  - On m_valid & m_ready, dcnt++. The handshake on dcnt = N-1 returns to LOAD with dcnt = 0, and s_ready = 1 in the next cycle.
  - m_coeff, m_last and m_valid are stable while m_ready = 0 (no retraction).
  - Output is registered: vec_in_valid at edge u gives m_valid = 1 and m_coeff = vec_in[0] in cycle u+1.
  - s_ready = 0 throughout DRAIN. There is no overlap of load and drain.
- vec_in_valid while in LOAD, ISSUE or DRAIN:
  - The data is ignored; capture and state are unchanged.
  - err_unexp is set and stays 1 until reset.
- Counters are log2(N) bits wide and never exceed N-1.
- Comparisons are unsigned W-bit. No other arithmetic is performed on the returned vector (passthrough).

Test Plan:
- Reset and idle: hold r = 1 for 2 cycles, then release -> s_ready = 1, vec_valid = 0, m_valid = 0, err_unexp = 0, vec_out all zero.
- Basic round trip, in-range inputs:
  - Stimulus: stream 0,1,2,3,4,5,6,7 with s_valid held high.
  - Required: vec_valid pulses exactly one cycle, the cycle after the 8th handshake, with vec_out[i] = i; s_ready = 0 from then on.
  - Then drive vec_in = {70,60,...,0} (vec_in[i] = 10*i) with a vec_in_valid pulse. Required: m_coeff = 0,10,...,70 on consecutive cycles with m_ready = 1; m_last only on the 70; s_ready = 1 the cycle after.
- Reduction boundaries:
  - Stimulus: stream 3328,3329,3330,4095,0,6658&4095,1,2.
  - Required: vec_out = 3328,0,1,766,0,3329-reduced value (6658 mod 4096 = 2562, below Q -> 2562),1,2.
- Output backpressure:
  - Stimulus: in DRAIN, toggle m_ready 1,0,0,1,...
  - Required: each element is held unchanged while m_ready = 0; all 8 are delivered in order exactly once; m_last holds with element 7 until accepted.
- Input gaps: s_valid low for random cycles between coefficients -> vector assembled in order; vec_valid only after the 8th handshake.
- Unexpected and reset mid-flight:
  - vec_in_valid pulse during LOAD -> err_unexp = 1 and no state change.
  - Assert r in DRAIN after 3 outputs -> next cycle m_valid = 0, s_ready = 1, err_unexp = 0; a fresh vector completes normally.

Source files
------------

// File: rtl/ntt_stream_bridge.sv
// ntt_stream_bridge
//   Stream-side front/back end for the 8-point NTT/iNTT datapath.
//   Collects N serial coefficients (valid/ready) into a vector, reducing each
//   to the canonical range [0, Q), and presents the vector with a one-cycle
//   vec_valid pulse. It then waits for the datapath's vec_in_valid pulse,
//   captures vec_in and replays it serially with m_last on the final element.
//   Only one transform is in flight at a time.
//
// Ports
//   clk, r                 clock, synchronous active-high reset
//   s_coeff/s_valid/s_ready serial input stream
//   vec_out/vec_valid      vector to the datapath, single-cycle valid pulse
//   vec_in/vec_in_valid    vector returned by the datapath
//   m_coeff/m_valid/m_ready/m_last  serial output stream
//   err_unexp              sticky flag: vec_in_valid seen outside WAIT
module ntt_stream_bridge #(
  parameter int N = 8,
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic         clk,
  input  logic         r,
  input  logic [W-1:0] s_coeff,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] vec_out [N-1:0],
  output logic         vec_valid,
  input  logic [W-1:0] vec_in [N-1:0],
  input  logic         vec_in_valid,
  output logic [W-1:0] m_coeff,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         err_unexp
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [W-1:0]  QW   = W'(Q);

  // Single conditional subtract is enough because 2^W - 1 < 2Q.
  function automatic logic [W-1:0] red(input logic [W-1:0] x);
    return (x >= QW) ? (x - QW) : x;
  endfunction

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, dcnt;
  logic [W-1:0]  cap [N-1:0];
  logic          s_fire, m_fire;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (r) state <= LOAD;
    else   state <= state_nxt;
  end

  // Outputs are decoded from registered state/counters/capture only, so the
  // output stream is effectively registered and cannot retract while stalled.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    vec_valid = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_coeff   = '0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && cnt == LAST) state_nxt = ISSUE;
      end
      ISSUE: begin
        vec_valid = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (vec_in_valid) state_nxt = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_coeff = cap[dcnt];
        m_last  = (dcnt == LAST);
        if (m_ready && dcnt == LAST) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      cnt       <= '0;
      dcnt      <= '0;
      err_unexp <= 1'b0;
      for (int i = 0; i < N; i++) begin
        vec_out[i] <= '0;
        cap[i]     <= '0;
      end
    end else begin
      // Load: reduce on the way in; untouched elements hold their value.
      if (s_fire) begin
        vec_out[cnt] <= red(s_coeff);
        cnt          <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      // Capture only in WAIT; a pulse coincident with ISSUE is an error.
      if (vec_in_valid && state == WAIT) begin
        for (int i = 0; i < N; i++) cap[i] <= vec_in[i];
      end
      if (vec_in_valid && state != WAIT) err_unexp <= 1'b1;
      // Drain
      if (m_fire) dcnt <= (dcnt == LAST) ? '0 : dcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ntt_stream_bridge.sv
module tb_ntt_stream_bridge;

  logic        clk = 1'b0;
  logic        r;
  logic [11:0] s_coeff;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] vec_out [7:0];
  logic        vec_valid;
  logic [11:0] vec_in [7:0];
  logic        vec_in_valid;
  logic [11:0] m_coeff;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        err_unexp;

  int n_chk  = 0;
  int n_fail = 0;

  ntt_stream_bridge #(.N(8), .W(12), .Q(3329)) dut (
    .clk(clk), .r(r),
    .s_coeff(s_coeff), .s_valid(s_valid), .s_ready(s_ready),
    .vec_out(vec_out), .vec_valid(vec_valid),
    .vec_in(vec_in), .vec_in_valid(vec_in_valid),
    .m_coeff(m_coeff), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LOAD always has s_ready = 1, so a held s_valid completes on the next edge.
  task automatic push(input logic [11:0] v);
    s_coeff = v;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic check_vec(input string tag, input logic [11:0] exp [8]);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(vec_out[i]), 32'(exp[i]));
  endtask

  task automatic send_vec_in(input logic [11:0] v [8]);
    for (int i = 0; i < 8; i++) vec_in[i] = v[i];
    vec_in_valid = 1'b1;
    tick();
    vec_in_valid = 1'b0;
  endtask

  // Drain with a repeating m_ready pattern; expectations advance only on a
  // handshake, so held values are checked on every stalled cycle too.
  task automatic drain(input string tag, input logic [11:0] exp [8], input logic [3:0] pat);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 64) begin
      chk($sformatf("%s_valid", tag), 32'(m_valid), 32'd1);
      chk($sformatf("%s_coeff%0d", tag, k), 32'(m_coeff), 32'(exp[k]));
      chk($sformatf("%s_last%0d", tag, k), 32'(m_last), 32'(k == 7));
      chk($sformatf("%s_sready", tag), 32'(s_ready), 32'd0);
      m_ready = pat[cyc % 4];
      tick();
      if (m_ready) k++;
      cyc++;
    end
    m_ready = 1'b0;
    chk($sformatf("%s_count", tag), 32'(k), 32'd8);
    chk($sformatf("%s_done_mvalid", tag), 32'(m_valid), 32'd0);
    chk($sformatf("%s_done_sready", tag), 32'(s_ready), 32'd1);
  endtask

  logic [11:0] exp_v [8];
  logic [11:0] in_v  [8];
  logic [11:0] ret_v [8];
  logic [11:0] red_v [8];

  initial begin
    r = 1'b1; s_coeff = '0; s_valid = 1'b0; vec_in_valid = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) vec_in[i] = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 r = 1'b0;
    tick();
    chk("rst_sready", 32'(s_ready), 32'd1);
    chk("rst_vvalid", 32'(vec_valid), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mcoeff", 32'(m_coeff), 32'd0);
    chk("rst_mlast", 32'(m_last), 32'd0);
    chk("rst_err", 32'(err_unexp), 32'd0);
    for (int i = 0; i < 8; i++) exp_v[i] = '0;
    check_vec("rst_vec", exp_v);

    // Basic round trip
    for (int i = 0; i < 7; i++) push(12'(i));
    chk("rt_no_early_pulse", 32'(vec_valid), 32'd0);
    push(12'd7);
    chk("rt_pulse", 32'(vec_valid), 32'd1);
    chk("rt_sready_issue", 32'(s_ready), 32'd0);
    for (int i = 0; i < 8; i++) exp_v[i] = 12'(i);
    check_vec("rt_vec", exp_v);
    tick();
    chk("rt_pulse_one_cycle", 32'(vec_valid), 32'd0);
    chk("rt_sready_wait", 32'(s_ready), 32'd0);
    chk("rt_mvalid_wait", 32'(m_valid), 32'd0);
    for (int i = 0; i < 8; i++) ret_v[i] = 12'(10 * i);
    send_vec_in(ret_v);
    drain("rt", ret_v, 4'b1111);
    chk("rt_err", 32'(err_unexp), 32'd0);

    // Reduction boundaries + output backpressure (m_ready 1,0,0,1,...)
    in_v[0] = 12'd3328; in_v[1] = 12'd3329; in_v[2] = 12'd3330; in_v[3] = 12'd4095;
    in_v[4] = 12'd0;    in_v[5] = 12'd2562; in_v[6] = 12'd1;    in_v[7] = 12'd2;
    red_v[0] = 12'd3328; red_v[1] = 12'd0;    red_v[2] = 12'd1; red_v[3] = 12'd766;
    red_v[4] = 12'd0;    red_v[5] = 12'd2562; red_v[6] = 12'd1; red_v[7] = 12'd2;
    for (int i = 0; i < 8; i++) push(in_v[i]);
    chk("red_pulse", 32'(vec_valid), 32'd1);
    check_vec("red_vec", red_v);
    tick();
    ret_v[0] = 12'd4095; ret_v[1] = 12'd3329; ret_v[2] = 12'd1;   ret_v[3] = 12'd2048;
    ret_v[4] = 12'd3328; ret_v[5] = 12'd77;   ret_v[6] = 12'd500; ret_v[7] = 12'd4000;
    send_vec_in(ret_v);
    drain("bp", ret_v, 4'b1001);
    // vec_out holds through WAIT/DRAIN until the next write
    check_vec("red_hold", red_v);

    // Input gaps, with an unexpected vec_in_valid pulse during LOAD
    for (int i = 0; i < 8; i++) exp_v[i] = 12'(100 + 3 * i);
    for (int i = 0; i < 8; i++) begin
      push(exp_v[i]);
      repeat ($urandom_range(0, 3)) begin
        chk("gap_no_pulse", 32'(vec_valid), 32'd0);
        tick();
      end
      if (i == 3) begin
        for (int j = 0; j < 8; j++) vec_in[j] = 12'd999;
        vec_in_valid = 1'b1;
        tick();
        vec_in_valid = 1'b0;
        chk("unexp_err", 32'(err_unexp), 32'd1);
        chk("unexp_sready", 32'(s_ready), 32'd1);
        chk("unexp_mvalid", 32'(m_valid), 32'd0);
      end
    end
    chk("gap_pulse", 32'(vec_valid), 32'd1);
    check_vec("gap_vec", exp_v);
    tick();
    for (int i = 0; i < 8; i++) ret_v[i] = 12'(200 + i);
    send_vec_in(ret_v);
    drain("gap", ret_v, 4'b1111);
    chk("unexp_sticky", 32'(err_unexp), 32'd1);

    // Reset in DRAIN after 3 outputs
    for (int i = 0; i < 8; i++) push(12'(50 + i));
    tick();
    for (int i = 0; i < 8; i++) ret_v[i] = 12'(300 + i);
    send_vec_in(ret_v);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rmid_coeff%0d", i), 32'(m_coeff), 32'(ret_v[i]));
      tick();
    end
    m_ready = 1'b0;
    chk("rmid_coeff3", 32'(m_coeff), 32'(ret_v[3]));
    r = 1'b1;
    tick();
    r = 1'b0;
    chk("rmid_mvalid", 32'(m_valid), 32'd0);
    chk("rmid_sready", 32'(s_ready), 32'd1);
    chk("rmid_err", 32'(err_unexp), 32'd0);
    chk("rmid_vvalid", 32'(vec_valid), 32'd0);
    for (int i = 0; i < 8; i++) exp_v[i] = '0;
    check_vec("rmid_vec", exp_v);

    // Fresh vector; vec_in_valid coincident with ISSUE is not captured
    for (int i = 0; i < 8; i++) exp_v[i] = 12'(4095 - i);
    for (int i = 0; i < 8; i++) push(exp_v[i]);
    chk("fr_pulse", 32'(vec_valid), 32'd1);
    for (int i = 0; i < 8; i++) red_v[i] = 12'(4095 - 3329 - i);
    check_vec("fr_vec", red_v);
    for (int i = 0; i < 8; i++) vec_in[i] = 12'd1234;
    vec_in_valid = 1'b1;
    tick();
    vec_in_valid = 1'b0;
    chk("issue_err", 32'(err_unexp), 32'd1);
    chk("issue_no_drain", 32'(m_valid), 32'd0);
    tick();
    chk("issue_still_wait", 32'(m_valid), 32'd0);
    for (int i = 0; i < 8; i++) ret_v[i] = 12'(11 * i + 5);
    send_vec_in(ret_v);
    drain("fr", ret_v, 4'b1101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
